// File: rtl/pp_gen_skid.sv
// pp_gen_skid
//   Front end of the 8x8 approximate multiplier's partial-product adder.
//   Operand pairs arrive on a valid/ready handshake and are held in a 2-entry
//   skid FIFO. The head entry is decoded into column-packed triangular partial
//   products p0..p7. Bit p_i[j] carries weight i+j. prod_valid is a one-cycle
//   delayed copy of the pop, which lines up with the adder's product register.
//
// Parameters
//   TRUNC_COLS  columns of weight < TRUNC_COLS are forced to 0 (0..15)
//   CNT_W       width of the accepted-operation counter
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   a_in, b_in  unsigned 8-bit operands
//   in_valid    operand pair offered
//   in_ready    FIFO not full (registered state only)
//   p0..p7      partial products, p_i is 15-2i bits wide
//   pp_valid    p0..p7 hold a valid head entry
//   pp_ready    adder consumes the head this cycle
//   prod_valid  adder product register holds the previous fire's result
//   op_count    accepted input handshakes, modulo 2^CNT_W
module pp_gen_skid #(
    parameter int unsigned TRUNC_COLS = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       a_in,
    input  logic [7:0]       b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [14:0]      p0,
    output logic [12:0]      p1,
    output logic [10:0]      p2,
    output logic [8:0]       p3,
    output logic [6:0]       p4,
    output logic [4:0]       p5,
    output logic [2:0]       p6,
    output logic             p7,
    output logic             pp_valid,
    input  logic             pp_ready,
    output logic             prod_valid,
    output logic [CNT_W-1:0] op_count
);

    logic [7:0]       a_q [2];
    logic [7:0]       b_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       occ_q;
    logic             prod_valid_q;
    logic [CNT_W-1:0] op_count_q;

    logic             push;
    logic             pop;
    logic [7:0]       head_a;
    logic [7:0]       head_b;
    logic [63:0]      pp_flat;

    // Ready depends on stored occupancy only, so a pop while full frees
    // the slot for the following cycle, not this one.
    assign in_ready = (occ_q != 2'd2);
    assign pp_valid = (occ_q != 2'd0);
    assign push     = in_valid & in_ready;
    assign pop      = pp_valid & pp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q[0]       <= '0;
            a_q[1]       <= '0;
            b_q[0]       <= '0;
            b_q[1]       <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
            prod_valid_q <= 1'b0;
            op_count_q   <= '0;
        end else begin
            if (push) begin
                a_q[wr_ptr_q] <= a_in;
                b_q[wr_ptr_q] <= b_in;
                wr_ptr_q      <= ~wr_ptr_q;
                op_count_q    <= op_count_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
            prod_valid_q <= pop;
        end
    end

    assign head_a = a_q[rd_ptr_q];
    assign head_b = b_q[rd_ptr_q];

    // Column w holds min(w,14-w)+1 terms; term i lands in p_i[w-i], which
    // sits at flat offset i*(16-i) + (w-i). Terms are gated by pp_valid so
    // an empty FIFO presents all-zero partial products.
    for (genvar w = 0; w < 15; w++) begin : g_col
        localparam int Lo = (w > 7) ? w - 7 : 0;
        localparam int Nt = ((w < 14 - w) ? w : 14 - w) + 1;
        for (genvar i = 0; i < Nt; i++) begin : g_term
            localparam int Idx = i * (16 - i) + w - i;
            if (w < int'(TRUNC_COLS)) begin : g_trunc
                assign pp_flat[Idx] = 1'b0;
            end else begin : g_keep
                assign pp_flat[Idx] = pp_valid & head_a[Lo+i] & head_b[w-Lo-i];
            end
        end
    end

    assign p0 = pp_flat[14:0];
    assign p1 = pp_flat[27:15];
    assign p2 = pp_flat[38:28];
    assign p3 = pp_flat[47:39];
    assign p4 = pp_flat[54:48];
    assign p5 = pp_flat[59:55];
    assign p6 = pp_flat[62:60];
    assign p7 = pp_flat[63];

    assign prod_valid = prod_valid_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_pp_gen_skid.sv
// Bench for pp_gen_skid: two instances (default parameters, and
// TRUNC_COLS=4 / CNT_W=4) share one stimulus stream. A queue-based model
// predicts every output each cycle; directed sections pin literal values.
module tb_pp_gen_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic        in_valid;
    logic        pp_ready;

    logic        d0_in_ready, d0_pp_valid, d0_prod_valid;
    logic [14:0] d0_p0;
    logic [12:0] d0_p1;
    logic [10:0] d0_p2;
    logic [8:0]  d0_p3;
    logic [6:0]  d0_p4;
    logic [4:0]  d0_p5;
    logic [2:0]  d0_p6;
    logic        d0_p7;
    logic [15:0] d0_op_count;

    logic        d1_in_ready, d1_pp_valid, d1_prod_valid;
    logic [14:0] d1_p0;
    logic [12:0] d1_p1;
    logic [10:0] d1_p2;
    logic [8:0]  d1_p3;
    logic [6:0]  d1_p4;
    logic [4:0]  d1_p5;
    logic [2:0]  d1_p6;
    logic        d1_p7;
    logic [3:0]  d1_op_count;

    logic [63:0] d0_flat;
    logic [63:0] d1_flat;

    int compares = 0;
    int fails    = 0;

    always #5 clk = ~clk;

    pp_gen_skid dut0 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_ready(d0_in_ready), .p0(d0_p0), .p1(d0_p1), .p2(d0_p2), .p3(d0_p3),
        .p4(d0_p4), .p5(d0_p5), .p6(d0_p6), .p7(d0_p7), .pp_valid(d0_pp_valid),
        .pp_ready(pp_ready), .prod_valid(d0_prod_valid), .op_count(d0_op_count)
    );

    pp_gen_skid #(.TRUNC_COLS(4), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
        .in_ready(d1_in_ready), .p0(d1_p0), .p1(d1_p1), .p2(d1_p2), .p3(d1_p3),
        .p4(d1_p4), .p5(d1_p5), .p6(d1_p6), .p7(d1_p7), .pp_valid(d1_pp_valid),
        .pp_ready(pp_ready), .prod_valid(d1_prod_valid), .op_count(d1_op_count)
    );

    assign d0_flat = {d0_p7, d0_p6, d0_p5, d0_p4, d0_p3, d0_p2, d0_p1, d0_p0};
    assign d1_flat = {d1_p7, d1_p6, d1_p5, d1_p4, d1_p3, d1_p2, d1_p1, d1_p0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Partial products straight from the column rule, packed as {p7..p0}.
    function automatic logic [63:0] model_pp(input logic [7:0] a, input logic [7:0] b,
                                             input int trunc);
        logic [63:0] r;
        int w, lo;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j <= 14 - 2 * i; j++) begin
                w  = i + j;
                lo = (w > 7) ? w - 7 : 0;
                if (w >= trunc) r[i*(16-i)+j] = a[lo+i] & b[w-lo-i];
            end
        end
        return r;
    endfunction

    // Sum of all bits at their weights: must equal a*b when nothing is truncated.
    function automatic int weighted_sum(input logic [63:0] f);
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j <= 14 - 2 * i; j++) begin
                if (f[i*(16-i)+j]) s += (1 << (i + j));
            end
        end
        return s;
    endfunction

    // Reference model: a queue of {a,b} plus a pop flag and a push counter.
    logic [15:0] mq[$];
    int          mcnt    = 0;
    bit          mpv     = 1'b0;
    bit          model_ok = 1'b0;
    bit          m_push, m_pop;
    logic [15:0] m_head;

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            mq.delete();
            mcnt     = 0;
            mpv      = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_push = (in_valid === 1'b1) && (mq.size() != 2);
            m_pop  = (mq.size() != 0) && (pp_ready === 1'b1);
            mpv    = m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back({a_in, b_in});
                mcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("in_ready0", 64'(d0_in_ready), 64'(mq.size() != 2));
            check("in_ready1", 64'(d1_in_ready), 64'(mq.size() != 2));
            check("pp_valid0", 64'(d0_pp_valid), 64'(mq.size() != 0));
            check("pp_valid1", 64'(d1_pp_valid), 64'(mq.size() != 0));
            check("prod_valid0", 64'(d0_prod_valid), 64'(mpv));
            check("prod_valid1", 64'(d1_prod_valid), 64'(mpv));
            check("op_count0", 64'(d0_op_count), 64'(mcnt[15:0]));
            check("op_count1", 64'(d1_op_count), 64'(mcnt[3:0]));
            if (mq.size() != 0) begin
                m_head = mq[0];
                check("pp0", d0_flat, model_pp(m_head[15:8], m_head[7:0], 0));
                check("pp1", d1_flat, model_pp(m_head[15:8], m_head[7:0], 4));
                check("sum0", 64'(weighted_sum(d0_flat)),
                      64'(int'(m_head[15:8]) * int'(m_head[7:0])));
            end else begin
                check("pp0_idle", d0_flat, 64'd0);
                check("pp1_idle", d1_flat, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pulses;
    logic [63:0] trunc_mask;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        pp_ready = 1'b0;
        a_in     = '0;
        b_in     = '0;
        tick();
        tick();
        check("rst_in_ready", 64'(d0_in_ready), 64'd1);
        check("rst_pp_valid", 64'(d0_pp_valid), 64'd0);
        check("rst_op_count", 64'(d0_op_count), 64'd0);
        check("rst_flat", d0_flat, 64'd0);
        rst = 1'b0;

        // FF x FF: every partial-product bit set; truncated instance clears low columns.
        a_in = 8'hFF; b_in = 8'hFF; in_valid = 1'b1; pp_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_pp_valid", 64'(d0_pp_valid), 64'd1);
        check("t1_all_ones", d0_flat, 64'hFFFF_FFFF_FFFF_FFFF);
        trunc_mask = 64'hF | (64'h7 << 15) | (64'h3 << 28) | (64'h1 << 39);
        check("t4_trunc", d1_flat, ~trunc_mask);
        tick();
        check("t1_prod_valid", 64'(d0_prod_valid), 64'd1);
        check("t1_op_count", 64'(d0_op_count), 64'd1);
        check("t1_drained", 64'(d0_pp_valid), 64'd0);

        // Single-bit products at the two triangle corners.
        a_in = 8'h01; b_in = 8'h80; in_valid = 1'b1;
        tick();
        check("t2_p0_7", d0_flat, 64'h0000_0000_0000_0080);
        a_in = 8'h80; b_in = 8'h01;
        tick();
        check("t2_p7", d0_flat, 64'h8000_0000_0000_0000);
        in_valid = 1'b0;
        tick();
        check("t2_drained", 64'(d0_pp_valid), 64'd0);

        // Back-pressure: fill, hold a third pair, then release.
        pp_ready = 1'b0; in_valid = 1'b1; a_in = 8'h11; b_in = 8'h22;
        tick();
        check("t3_ready_occ1", 64'(d0_in_ready), 64'd1);
        a_in = 8'h33; b_in = 8'h44;
        tick();
        check("t3_full", 64'(d0_in_ready), 64'd0);
        a_in = 8'h55; b_in = 8'h66;
        tick();
        check("t3_still_full", 64'(d0_in_ready), 64'd0);
        check("t3_cnt_held", 64'(d0_op_count), 64'd5);
        check("t3_head1", d0_flat, model_pp(8'h11, 8'h22, 0));
        pp_ready = 1'b1;
        tick();
        check("t3_ready_after_pop", 64'(d0_in_ready), 64'd1);
        check("t3_cnt_no_push", 64'(d0_op_count), 64'd5);
        check("t3_head2", d0_flat, model_pp(8'h33, 8'h44, 0));
        tick();
        in_valid = 1'b0;
        check("t3_third_accepted", 64'(d0_op_count), 64'd6);
        check("t3_head3", d0_flat, model_pp(8'h55, 8'h66, 0));
        tick();
        check("t3_drained", 64'(d0_pp_valid), 64'd0);

        // Reset while full discards everything.
        pp_ready = 1'b0; in_valid = 1'b1; a_in = 8'hA5; b_in = 8'h5A;
        tick();
        tick();
        check("t5_full", 64'(d0_in_ready), 64'd0);
        rst = 1'b1; in_valid = 1'bx; pp_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; pp_ready = 1'b0;
        check("t5_pp_valid", 64'(d0_pp_valid), 64'd0);
        check("t5_in_ready", 64'(d0_in_ready), 64'd1);
        check("t5_op_count", 64'(d0_op_count), 64'd0);
        check("t5_prod_valid", 64'(d0_prod_valid), 64'd0);
        check("t5_flat0", d0_flat, 64'd0);
        check("t5_flat1", d1_flat, 64'd0);

        // 17 back-to-back pushes into the 4-bit counter instance.
        pp_ready = 1'b1; in_valid = 1'b1; pulses = 0;
        for (int k = 0; k < 17; k++) begin
            check("t6_in_ready", 64'(d1_in_ready), 64'd1);
            a_in = 8'($urandom); b_in = 8'($urandom);
            tick();
            if (d1_prod_valid) pulses++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            if (d1_prod_valid) pulses++;
        end
        check("t6_op_count_wrap", 64'(d1_op_count), 64'd1);
        check("t6_pulses", 64'(pulses), 64'd17);

        // Random traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            pp_ready = ($urandom_range(0, 2) != 0) ^ (k[9] & ($urandom_range(0, 1) == 0));
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; pp_ready = 1'b1;
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
